// File: rtl/wb_regfile_pkg.sv
// Shared defines for the write-back register file: bus widths, register
// count, canonical constants and the reset polarity used by every file.
package wb_regfile_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;

    localparam logic [RegBus-1:0]     ZeroWord   = 32'h0000_0000;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = 5'b00000;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

    // Reset is asserted when the rst pin is at this level.
    localparam logic RstActiveLow = 1'b0;

    typedef logic [RegBus-1:0]     reg_word_t;
    typedef logic [RegAddrBus-1:0] reg_addr_t;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO register pair. Both halves are written together when whilo is set.
// Build option: WB_REGFILE_BYPASS_EN forwards the incoming write data to the
// outputs in the same cycle; otherwise the outputs show stored state only.
import wb_regfile_pkg::*;

module hilo_reg (
    input  logic              clk,
    input  logic              rst,
    input  logic              whilo,
    input  logic [RegBus-1:0] hi_wdata,
    input  logic [RegBus-1:0] lo_wdata,
    output logic [RegBus-1:0] hi,
    output logic [RegBus-1:0] lo
);

    reg_word_t hi_reg;
    reg_word_t lo_reg;

    // Stored HI/LO: cleared asynchronously, updated as a pair on write.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstActiveLow) begin
            hi_reg <= ZeroWord;
            lo_reg <= ZeroWord;
        end else if (whilo == WriteEnable) begin
            hi_reg <= hi_wdata;
            lo_reg <= lo_wdata;
        end
    end

    // Read mux: zero in reset, optional same-cycle forwarding, else state.
    always_comb begin
        hi = hi_reg;
        lo = lo_reg;
        if (rst == RstActiveLow) begin
            hi = ZeroWord;
            lo = ZeroWord;
        end
`ifdef WB_REGFILE_BYPASS_EN
        else if (whilo == WriteEnable) begin
            hi = hi_wdata;
            lo = lo_wdata;
        end
`endif
    end

endmodule

// File: rtl/wb_regfile.sv
// Architectural state at the tail of the pipeline: 32x32 GPR file with two
// combinational read ports, plus the HI/LO pair (hilo_reg).
// Build option: WB_REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding on both GPR ports and on hi_o/lo_o.
import wb_regfile_pkg::*;

module wb_regfile (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_wreg,
    input  logic [RegAddrBus-1:0] wb_wd,
    input  logic [RegBus-1:0]     wb_wdata,
    input  logic                  wb_whilo,
    input  logic [RegBus-1:0]     wb_hi,
    input  logic [RegBus-1:0]     wb_lo,
    input  logic                  re1,
    input  logic [RegAddrBus-1:0] raddr1,
    output logic [RegBus-1:0]     rdata1,
    input  logic                  re2,
    input  logic [RegAddrBus-1:0] raddr2,
    output logic [RegBus-1:0]     rdata2,
    output logic [RegBus-1:0]     hi_o,
    output logic [RegBus-1:0]     lo_o
);

    localparam int NumReadPorts = 2;

    // Register array; regs_reg[0] is never written so it always holds zero.
    // Asynchronous clear of the whole array rules out a RAM macro here.
    reg_word_t regs_reg [RegNum];

    // Read ports gathered into arrays so one mux description serves both.
    logic      rd_en   [NumReadPorts];
    reg_addr_t rd_addr [NumReadPorts];

    assign rd_en[0]   = re1;
    assign rd_en[1]   = re2;
    assign rd_addr[0] = raddr1;
    assign rd_addr[1] = raddr2;

    // GPR write: cleared on reset, single write port, address 0 discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstActiveLow) begin
            for (int i = 0; i < RegNum; i++) begin
                regs_reg[i] <= ZeroWord;
            end
        end else if (wb_wreg == WriteEnable && wb_wd != NOPRegAddr) begin
            regs_reg[wb_wd] <= wb_wdata;
        end
    end

    // One independent read mux per port, in strict priority order:
    // reset, r0, disabled port, optional forwarding, stored value.
    for (genvar gi = 0; gi < NumReadPorts; gi++) begin : g_rd
        reg_word_t data_next;

        // Priority read mux for port gi.
        always_comb begin
            data_next = ZeroWord;
            if (rst == RstActiveLow) begin
                data_next = ZeroWord;
            end else if (rd_addr[gi] == NOPRegAddr) begin
                data_next = ZeroWord;
            end else if (rd_en[gi] == ReadDisable) begin
                data_next = ZeroWord;
            end
`ifdef WB_REGFILE_BYPASS_EN
            else if (wb_wreg == WriteEnable && wb_wd == rd_addr[gi]) begin
                data_next = wb_wdata;
            end
`endif
            else begin
                data_next = regs_reg[rd_addr[gi]];
            end
        end
    end

    assign rdata1 = g_rd[0].data_next;
    assign rdata2 = g_rd[1].data_next;

    hilo_reg u_hilo (
        .clk      (clk),
        .rst      (rst),
        .whilo    (wb_whilo),
        .hi_wdata (wb_hi),
        .lo_wdata (wb_lo),
        .hi       (hi_o),
        .lo       (lo_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a vector table for single-cycle behaviour
// plus hand-written reset sequences. Expectations follow the build option.
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    wb_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .wb_wreg  (wb_wreg),
        .wb_wd    (wb_wd),
        .wb_wdata (wb_wdata),
        .wb_whilo (wb_whilo),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        re1;
        logic [4:0]  a1;
        logic        re2;
        logic [4:0]  a2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                         input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                         input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2);
        wb_wreg  = wreg;
        wb_wd    = wd;
        wb_wdata = wdata;
        wb_whilo = whilo;
        wb_hi    = hi;
        wb_lo    = lo;
        re1      = r1;
        raddr1   = a1;
        re2      = r2;
        raddr2   = a2;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                             input logic [31:0] eh, input logic [31:0] el);
        check({tag, ".rdata1"}, rdata1, e1);
        check({tag, ".rdata2"}, rdata2, e2);
        check({tag, ".hi_o"}, hi_o, eh);
        check({tag, ".lo_o"}, lo_o, el);
    endtask

    initial begin
        // Fields: wreg wd wdata whilo hi lo re1 a1 re2 a2 exp1 exp2 exp_hi exp_lo
        // write r7, read it the same cycle on port 1
        vecs.push_back('{1, 7, 32'h12345678, 0, 0, 0, 1, 7, 0, 7,
                         BYP ? 32'h12345678 : 32'h0, 0, 0, 0});
        // r7 visible on both ports next cycle
        vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 32'h12345678, 32'h12345678, 0, 0});
        // disabled port 1 returns 0
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 7, 1, 7, 0, 32'h12345678, 0, 0});
        // write r0: address 0 wins over forwarding
        vecs.push_back('{1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0});
        // same-cycle hazard on r3, both ports
        vecs.push_back('{1, 3, 32'hA5A5A5A5, 0, 0, 0, 1, 3, 1, 3,
                         BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 3, 1, 3, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0});
        // HI/LO write then hold with different inputs
        vecs.push_back('{0, 0, 0, 1, 32'h1, 32'h2, 1, 3, 1, 7, 32'hA5A5A5A5, 32'h12345678,
                         BYP ? 32'h1 : 32'h0, BYP ? 32'h2 : 32'h0});
        vecs.push_back('{0, 0, 0, 0, 32'h99, 32'h77, 0, 3, 0, 7, 0, 0, 32'h1, 32'h2});
        // dual-port independence: r1 then r2, crossed reads
        vecs.push_back('{1, 1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1, 32'h2});
        vecs.push_back('{1, 2, 32'h22, 0, 0, 0, 1, 2, 1, 1,
                         BYP ? 32'h22 : 32'h0, 32'h11, 32'h1, 32'h2});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 2, 1, 1, 32'h22, 32'h11, 32'h1, 32'h2});
        // write enable low with matching address: no update, no forwarding
        vecs.push_back('{0, 1, 32'hDEAD0000, 0, 0, 0, 1, 1, 1, 1, 32'h11, 32'h11, 32'h1, 32'h2});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 32'h11, 32'h22, 32'h1, 32'h2});

        // Power-up reset with nonzero read addresses
        drive(0, 0, 0, 0, 0, 0, 1, 7, 1, 3);
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        check_all("por", 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Table: drive after posedge, sample at negedge, commit at next posedge
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].wreg, vecs[i].wd, vecs[i].wdata, vecs[i].whilo, vecs[i].hi,
                  vecs[i].lo, vecs[i].re1, vecs[i].a1, vecs[i].re2, vecs[i].a2);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].exp1, vecs[i].exp2,
                      vecs[i].exp_hi, vecs[i].exp_lo);
            $display("vec%0d: r1=%08h r2=%08h hi=%08h lo=%08h", i, rdata1, rdata2, hi_o, lo_o);
        end

        // Mid-cycle reset: load r5 and HI/LO, then assert rst with writes pending
        @(posedge clk);
        #1 drive(1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1, 5, 1, 5);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 1, 5, 1, 5);
        @(negedge clk);
        check_all("preload", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        $display("preload: r1=%08h r2=%08h hi=%08h lo=%08h", rdata1, rdata2, hi_o, lo_o);
        drive(1, 5, 32'hCAFEF00D, 1, 32'h5, 32'h6, 1, 5, 1, 5);
        #1 rst = 1'b0;
        #1;
        check_all("rst_async", 0, 0, 0, 0);
        $display("rst_async: r1=%08h r2=%08h hi=%08h lo=%08h", rdata1, rdata2, hi_o, lo_o);
        // posedge with rst low and writes enabled: write must be lost
        drive(1, 6, 32'h55, 1, 32'h7, 32'h8, 1, 6, 1, 5);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(0, 0, 0, 0, 32'h9, 32'h9, 1, 5, 1, 6);
        @(negedge clk);
        check_all("post_rst", 0, 0, 0, 0);
        $display("post_rst: r1=%08h r2=%08h hi=%08h lo=%08h", rdata1, rdata2, hi_o, lo_o);

        // Normal writes resume after reset release
        @(posedge clk);
        #1 drive(1, 5, 32'h0BADCAFE, 0, 0, 0, 1, 5, 0, 5);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 1, 5, 1, 6);
        @(negedge clk);
        check_all("resume", 32'h0BADCAFE, 0, 0, 0);
        $display("resume: r1=%08h r2=%08h hi=%08h lo=%08h", rdata1, rdata2, hi_o, lo_o);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
